// File: rtl/regfile_tmr_mp.sv
// Multi-read-port register file with bypass, hardwired x0 and optional TMR storage + scrubber.
// Define REGFILE_TMR_EN to build the triple-redundant storage and background scrubber.
module regfile_tmr_mp #(
   parameter int XLEN     = 32,
   parameter int NREGS    = 32,
   parameter int AW       = $clog2(NREGS),
   parameter int NRP      = 2,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic                clk,
   input  logic                rst_in,
   input  logic                we,
   input  logic [AW-1:0]       wa,
   input  logic [XLEN-1:0]     wd,
   input  logic [NRP*AW-1:0]   ra,
   output logic [NRP*XLEN-1:0] rd,
   output logic                scrub_err,
   output logic [15:0]         err_cnt
);

   function automatic logic addr_ok(input logic [AW-1:0] a);
      return int'(a) < NREGS;
   endfunction

   function automatic logic addr_zero(input logic [AW-1:0] a);
      return (ZERO_REG != 0) && (a == '0);
   endfunction

   logic w_wr_ok;
   assign w_wr_ok = we && !rst_in && addr_ok(wa) && !addr_zero(wa);

   logic [XLEN-1:0] r_mem_a [NREGS];

`ifdef REGFILE_TMR_EN
   logic [XLEN-1:0] r_mem_b [NREGS];
   logic [XLEN-1:0] r_mem_c [NREGS];
   logic [AW-1:0]   r_scrub_ptr;
   logic            r_scrub_err;
   logic [15:0]     r_err_cnt;

   function automatic logic [XLEN-1:0] vote(input logic [XLEN-1:0] a, b, c);
      return (a & b) | (a & c) | (b & c);
   endfunction

   logic [XLEN-1:0] w_scrub_vote;
   logic            w_scrub_fix;
   logic [AW-1:0]   w_scrub_next;

   assign w_scrub_vote = vote(r_mem_a[r_scrub_ptr], r_mem_b[r_scrub_ptr], r_mem_c[r_scrub_ptr]);
   // A writeback to the address under scrub already refreshes all copies, so it pre-empts the repair.
   assign w_scrub_fix  = ((r_mem_a[r_scrub_ptr] != r_mem_b[r_scrub_ptr]) ||
                          (r_mem_a[r_scrub_ptr] != r_mem_c[r_scrub_ptr])) &&
                         !(w_wr_ok && (wa == r_scrub_ptr));
   assign w_scrub_next = (r_scrub_ptr == AW'(NREGS - 1)) ? AW'((ZERO_REG != 0) ? 1 : 0)
                                                         : r_scrub_ptr + 1'b1;

   // NOTE: the storage arrays are reset because x0..xN must read 0 after reset; this costs a
   // reset mux per bit and prevents mapping onto RAM macros, which is acceptable for a 32-entry file.
   // NOTE: sequential state uses non-blocking assignments so every reader sees pre-edge values.
   always_ff @(posedge clk) begin
      if (rst_in) begin
         for (int i = 0; i < NREGS; i++) begin
            r_mem_a[i] <= '0;
            r_mem_b[i] <= '0;
            r_mem_c[i] <= '0;
         end
         r_scrub_ptr <= '0;
         r_scrub_err <= 1'b0;
         r_err_cnt   <= '0;
      end else begin
         r_scrub_err <= 1'b0;
         if (w_scrub_fix) begin
            r_mem_a[r_scrub_ptr] <= w_scrub_vote;
            r_mem_b[r_scrub_ptr] <= w_scrub_vote;
            r_mem_c[r_scrub_ptr] <= w_scrub_vote;
            r_scrub_err          <= 1'b1;
            if (r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
         end
         if (w_wr_ok) begin
            r_mem_a[wa] <= wd;
            r_mem_b[wa] <= wd;
            r_mem_c[wa] <= wd;
         end
         r_scrub_ptr <= w_scrub_next;
      end
   end

   assign scrub_err = r_scrub_err;
   assign err_cnt   = r_err_cnt;
`else
   always_ff @(posedge clk) begin
      if (rst_in) begin
         for (int i = 0; i < NREGS; i++) r_mem_a[i] <= '0;
      end else if (w_wr_ok) begin
         r_mem_a[wa] <= wd;
      end
   end

   assign scrub_err = 1'b0;
   assign err_cnt   = '0;
`endif

   for (genvar p = 0; p < NRP; p++) begin : g_rd
      logic [AW-1:0]   w_ra;
      logic [XLEN-1:0] w_store;
      logic [XLEN-1:0] w_rd;

      assign w_ra = ra[p*AW +: AW];

      // NOTE: every branch of this always_comb starts from a default so no latch is inferred.
      always_comb begin
         w_store = '0;
         if (addr_ok(w_ra)) begin
`ifdef REGFILE_TMR_EN
            w_store = vote(r_mem_a[w_ra], r_mem_b[w_ra], r_mem_c[w_ra]);
`else
            w_store = r_mem_a[w_ra];
`endif
         end
      end

      always_comb begin
         w_rd = w_store;
         if (rst_in)                                      w_rd = '0;
         else if ((BYPASS != 0) && w_wr_ok && wa == w_ra) w_rd = wd;
         else if (!addr_ok(w_ra) || addr_zero(w_ra))      w_rd = '0;
      end

      assign rd[p*XLEN +: XLEN] = w_rd;
   end

endmodule

// File: tb/tb_regfile_tmr_mp.sv
// Scoreboard bench for regfile_tmr_mp: bypassing and non-bypassing instances against an array model.
// TMR scrubber scenarios run only when REGFILE_TMR_EN is defined.
module tb_regfile_tmr_mp;

   logic        clk = 1'b0;
   logic        rst_in = 1'b1;
   logic        we = 1'b0;
   logic [4:0]  wa = '0;
   logic [31:0] wd = '0;
   logic [9:0]  ra = '0;
   logic [63:0] rd, rd_nb;
   logic        scrub_err, scrub_err_nb;
   logic [15:0] err_cnt, err_cnt_nb;

   always #5 clk = ~clk;

   regfile_tmr_mp #(.BYPASS(1)) dut (
      .clk(clk), .rst_in(rst_in), .we(we), .wa(wa), .wd(wd), .ra(ra),
      .rd(rd), .scrub_err(scrub_err), .err_cnt(err_cnt));

   regfile_tmr_mp #(.BYPASS(0)) dut_nb (
      .clk(clk), .rst_in(rst_in), .we(we), .wa(wa), .wd(wd), .ra(ra),
      .rd(rd_nb), .scrub_err(scrub_err_nb), .err_cnt(err_cnt_nb));

   typedef struct {
      logic [31:0] rd0, rd1, nb0, nb1;
      bit          skip_scrub;
      string       tag;
   } exp_t;

   exp_t        sb_q[$];
   int          n_cmp = 0;
   int          n_err = 0;
   bit          skip_scrub = 0;
   logic [31:0] model_mem [32];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Architectural view: x0 is zero, a writeback is visible to the same-cycle read only with bypass.
   function automatic logic [31:0] model_rd(input bit rst_v, we_v, byp, input int wa_v,
                                            input logic [31:0] wd_v, input int ra_v);
      if (rst_v)                                       return 32'h0;
      if (byp && we_v && wa_v == ra_v && wa_v != 0)    return wd_v;
      if (ra_v == 0)                                   return 32'h0;
      return model_mem[ra_v];
   endfunction

   task automatic cycle(input bit rst_v, we_v, input int wa_v, input logic [31:0] wd_v,
                        input int ra0_v, ra1_v, input string tag_v);
      exp_t e;
      rst_in = rst_v; we = we_v; wa = 5'(wa_v); wd = wd_v;
      ra = {5'(ra1_v), 5'(ra0_v)};
      e.rd0 = model_rd(rst_v, we_v, 1, wa_v, wd_v, ra0_v);
      e.rd1 = model_rd(rst_v, we_v, 1, wa_v, wd_v, ra1_v);
      e.nb0 = model_rd(rst_v, we_v, 0, wa_v, wd_v, ra0_v);
      e.nb1 = model_rd(rst_v, we_v, 0, wa_v, wd_v, ra1_v);
      e.skip_scrub = skip_scrub;
      e.tag = tag_v;
      sb_q.push_back(e);
      @(posedge clk);
      if (rst_v) begin
         for (int i = 0; i < 32; i++) model_mem[i] = 32'h0;
      end else if (we_v && wa_v != 0) begin
         model_mem[wa_v] = wd_v;
      end
      #1;
   endtask

   always @(negedge clk) begin
      if (sb_q.size() > 0) begin
         exp_t e;
         e = sb_q.pop_front();
         check({e.tag, ".rd0"},    rd[31:0],     e.rd0);
         check({e.tag, ".rd1"},    rd[63:32],    e.rd1);
         check({e.tag, ".nb_rd0"}, rd_nb[31:0],  e.nb0);
         check({e.tag, ".nb_rd1"}, rd_nb[63:32], e.nb1);
         if (!e.skip_scrub) begin
            check({e.tag, ".scrub_err"}, 32'(scrub_err), 32'h0);
            check({e.tag, ".err_cnt"},   32'(err_cnt),   32'h0);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 32; i++) model_mem[i] = 32'hX;
      @(posedge clk); #1;
      cycle(1, 0, 0, 0, 0, 0, "reset");
      cycle(1, 1, 3, 32'h1234, 3, 3, "reset_hold");
      for (int a = 0; a < 32; a++) cycle(0, 0, 0, 0, a, 31 - a, "read_all_zero");

      cycle(0, 1, 3, 32'd5, 0, 0, "write_r3");
      cycle(1, 0, 0, 0, 3, 3, "rst_forces_rd");
      cycle(0, 0, 0, 0, 3, 3, "r3_cleared");

      cycle(0, 1, 5, 32'hDEADBEEF, 1, 2, "write_r5");
      cycle(0, 0, 0, 0, 5, 5, "read_r5");
      cycle(0, 1, 0, 32'h1, 0, 0, "write_x0");
      cycle(0, 0, 0, 0, 0, 5, "read_x0");

      cycle(0, 1, 7, 32'hA5A5A5A5, 5, 7, "bypass_r7");
      cycle(0, 0, 0, 0, 7, 7, "read_r7");

      cycle(0, 1, 9, 32'h99999999, 9, 9, "write_r9");
      cycle(1, 1, 9, 32'h12345678, 9, 9, "rst_and_we");
      cycle(0, 0, 0, 0, 9, 7, "r9_after_rst");

      for (int n = 0; n < 400; n++) begin
         int ra0_r, ra1_r, wa_r;
         ra0_r = $urandom_range(0, 31);
         ra1_r = $urandom_range(0, 31);
         wa_r  = ($urandom_range(0, 3) == 0) ? ra1_r : $urandom_range(0, 31);
         cycle(($urandom_range(0, 63) == 0), $urandom_range(0, 1), wa_r, $urandom,
               ra0_r, ra1_r, "random");
      end

`ifdef REGFILE_TMR_EN
      skip_scrub = 1;
      begin
         int pulses;
         cycle(0, 1, 4, 32'h0F0F0F0F, 0, 0, "tmr_write_r4");
         dut.r_mem_b[4] = 32'hFFFFFFFF;
         pulses = 0;
         cycle(0, 0, 0, 0, 4, 4, "tmr_vote_r4");
         if (scrub_err) pulses++;
         for (int n = 0; n < 34; n++) begin
            cycle(0, 0, 0, 0, 4, 1, "tmr_scrub_wait");
            if (scrub_err) pulses++;
         end
         check("tmr_pulse_count", 32'(pulses), 32'd1);
         check("tmr_err_cnt", 32'(err_cnt), 32'd1);
         check("tmr_mem_b_restored", dut.r_mem_b[4], 32'h0F0F0F0F);

         for (int n = 0; n < 64 && dut.r_scrub_ptr != 5'd6; n++)
            cycle(0, 0, 0, 0, 6, 6, "tmr_ptr_wait");
         check("tmr_ptr_reached_6", 32'(dut.r_scrub_ptr), 32'd6);
         dut.r_mem_c[6] = 32'hCAFEF00D;
         cycle(0, 1, 6, 32'h600DD00D, 6, 6, "tmr_write_wins");
         check("tmr_no_pulse", 32'(scrub_err), 32'h0);
         check("tmr_err_cnt_same", 32'(err_cnt), 32'd1);
         check("tmr_copy_a", dut.r_mem_a[6], 32'h600DD00D);
         check("tmr_copy_b", dut.r_mem_b[6], 32'h600DD00D);
         check("tmr_copy_c", dut.r_mem_c[6], 32'h600DD00D);
         cycle(0, 0, 0, 0, 6, 4, "tmr_after_write");
         check("tmr_no_late_pulse", 32'(scrub_err), 32'h0);
      end
`endif

      repeat (2) @(negedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
